bit_pattern_generator: RTL and testbench
========================================

Name: bit_pattern_generator

Overview:
- Serial inverse of the lab 4 bit counter: takes a target population count N and builds a WIDTH-bit word with exactly N ones.
- Ones are shifted in one per clock, LSB-justified or MSB-justified.
- Uses the same start/done handshake as the counter: start is a level, done is held until start is released.
- Sits beside the counter in the lab 4 top level. Its pattern output can loop back into the counter for on-board checking.

Parameters:
- WIDTH, 8, pattern width in bits.
- CNT_W, $clog2(WIDTH+1) (4), width of the count input and the internal remaining counter.

Ports:
- CLOCK_50  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  level request; sampled only in S_IDLE.
- count_in  in  CNT_W  target number of ones; latched on start.
- align  in  1  0 = ones fill from bit 0 upward; 1 = ones fill from bit WIDTH-1 downward; latched on start.
- pattern  out  WIDTH  generated word (registered).
- busy  out  1  high in S_FILL.
- done  out  1  high in S_DONE.
- err  out  1  high in S_DONE when the latched count_in exceeded WIDTH.
- chk_fail  out  1  self-check mismatch flag (see Optional Feature).

Behaviour:
- Reset (synchronous, wins over everything):
  - ps = S_IDLE.
  - pattern, remaining, align_q, err_q all 0.
  - busy, done, err, chk_fail all 0.
  - Takes effect at the next edge from any state, including mid-fill.
- FSM states: S_IDLE, S_FILL, S_DONE.
- S_IDLE:
  - pattern holds its last value.
  - start = 1 at an edge: pattern <= 0; remaining <= min(count_in, WIDTH); err_q <= (count_in > WIDTH); align_q <= align; ns = S_FILL.
  - start = 0: stay.
- S_FILL:
  - busy = 1.
  - remaining != 0: shift one 1 in and decrement remaining.
    - align_q = 0: pattern <= {pattern[WIDTH-2:0], 1'b1}.
    - align_q = 1: pattern <= {1'b1, pattern[WIDTH-1:1]}.
  - remaining == 0: pattern holds; ns = S_DONE.
  - Occupies exactly N+1 cycles, where N is the clamped count. N = 0 gives 1 cycle and pattern = 0.
  - start and count_in are ignored while in S_FILL.
- S_DONE:
  - done = 1; err = err_q.
  - Stay while start = 1. Go to S_IDLE when start = 0, so a held start never retriggers.
  - pattern remains stable through S_DONE and the following S_IDLE.
- Latency: start sampled at edge k; busy from k+1; done first high at edge k+N+2.
- Clamp: count_in values WIDTH+1 .. 2^CNT_W-1 give an all-ones pattern plus err = 1. err clears on the next accepted start.
- Invariant: in S_DONE, popcount(pattern) equals the clamped N, and the ones are contiguous from the chosen end.

Optional Feature:
- Macro BITGEN_SELFCHECK_EN.
- Defined:
  - A combinational popcount of pattern is compared against a latched copy of the clamped N.
  - chk_fail is registered: it is set on any cycle in S_DONE where they differ, and cleared on Reset or on an accepted start.
  - A simulation-only assertion fires on mismatch.
- Undefined: chk_fail is tied to 0 and no popcount logic is synthesized.

Decomposition:
- Package bitgen_pkg:
  - state enum {S_IDLE, S_FILL, S_DONE} as logic [1:0].
  - BITGEN_WIDTH_DEFAULT = 8.
  - Function clamp_count(count, width).
- One sub-module: bitgen_shift_reg (WIDTH).
  - Inputs: clr, shift_en, dir, and the clock/reset.
  - Output: q.
  - Holds pattern and performs the fill shifts.
- FSM, the remaining counter and the self-check stay in the top module.

Test Plan:
- Reset mid-fill: count_in=6, align=0, start; assert Reset 3 cycles later -> next edge pattern=8'h00, busy=0, done=0, ps=S_IDLE.
- LSB fill: count_in=3, align=0, start held -> busy for 4 cycles; done at k+5; pattern=8'b0000_0111; err=0; done stays high until start drops, then S_IDLE with pattern held.
- MSB fill and full fill: count_in=5, align=1 -> pattern=8'b1111_1000. count_in=8, align=0 -> pattern=8'hFF, done at k+10.
- Zero and clamp: count_in=0 -> one busy cycle, pattern=8'h00, err=0. count_in=12 -> pattern=8'hFF, err=1; next start with count_in=2 clears err and gives pattern=8'h03.
- Ignored inputs: change count_in and align, and toggle start, during S_FILL -> result unchanged. Start held across S_DONE->S_IDLE causes no retrigger.
- Sweep: all count_in 0..15 × align {0,1} -> popcount(pattern)=min(count_in,8) and contiguous ones. With BITGEN_SELFCHECK_EN defined, chk_fail stays 0 throughout.

Source files
------------

// File: rtl/bitgen_pkg.sv
// Shared types and helpers for the serial bit-pattern generator.
package bitgen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int BITGEN_WIDTH_DEFAULT = 8;

  // Requested counts above the word width saturate to a full word.
  function automatic int unsigned clamp_count(input int unsigned count, input int unsigned width);
    return (count > width) ? width : count;
  endfunction

endpackage

// File: rtl/bitgen_shift_reg.sv
// Pattern register: cleared on an accepted start, then one 1 shifted in per enabled cycle
// from bit 0 (i_dir=0) or from bit WIDTH-1 (i_dir=1).
module bitgen_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_shift_en,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_shift_en) begin
      if (i_dir) r_q <= {1'b1, r_q[WIDTH-1:1]};
      else       r_q <= {r_q[WIDTH-2:0], 1'b1};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bit_pattern_generator.sv
// Builds a WIDTH-bit word holding exactly min(count_in, WIDTH) contiguous ones, one per clock.
// Optional popcount self-check on the finished word: BITGEN_SELFCHECK_EN.
module bit_pattern_generator
  import bitgen_pkg::*;
#(
  parameter int WIDTH = BITGEN_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count_in,
  input  logic             align,
  output logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             chk_fail
);

  state_t           r_ps;
  state_t           w_ns;
  logic [CNT_W-1:0] r_remaining;
  logic             r_align_q;
  logic             r_err_q;
  logic             w_accept;
  logic             w_shift_en;
  logic [CNT_W-1:0] w_clamped;
  logic             w_over;

  assign w_accept   = (r_ps == S_IDLE) && start;
  assign w_shift_en = (r_ps == S_FILL) && (r_remaining != '0);
  assign w_clamped  = CNT_W'(clamp_count(32'(count_in), WIDTH));
  assign w_over     = (32'(count_in) > 32'(WIDTH));

  always_ff @(posedge CLOCK_50) begin
    if (Reset) r_ps <= S_IDLE;
    else       r_ps <= w_ns;
  end

  // S_DONE waits for start to drop so a held start cannot retrigger.
  always_comb begin
    w_ns = r_ps;
    case (r_ps)
      S_IDLE:  if (start) w_ns = S_FILL;
      S_FILL:  if (r_remaining == '0) w_ns = S_DONE;
      S_DONE:  if (!start) w_ns = S_IDLE;
      default: w_ns = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    case (r_ps)
      S_FILL:  busy = 1'b1;
      S_DONE:  begin
        done = 1'b1;
        err  = r_err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_remaining <= '0;
      r_align_q   <= 1'b0;
      r_err_q     <= 1'b0;
    end else if (w_accept) begin
      r_remaining <= w_clamped;
      r_align_q   <= align;
      r_err_q     <= w_over;
    end else if (w_shift_en) begin
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  bitgen_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .i_clk      (CLOCK_50),
    .i_rst      (Reset),
    .i_clr      (w_accept),
    .i_shift_en (w_shift_en),
    .i_dir      (r_align_q),
    .o_q        (pattern)
  );

`ifdef BITGEN_SELFCHECK_EN
  logic [CNT_W-1:0] r_chk_n;
  logic [CNT_W-1:0] w_popcnt;
  logic             r_chk_fail;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + CNT_W'(pattern[i]);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_chk_n    <= '0;
      r_chk_fail <= 1'b0;
    end else if (w_accept) begin
      r_chk_n    <= w_clamped;
      r_chk_fail <= 1'b0;
    end else if ((r_ps == S_DONE) && (w_popcnt != r_chk_n)) begin
      r_chk_fail <= 1'b1;
    end
  end

  assign chk_fail = r_chk_fail;

`ifndef SYNTHESIS
  a_popcount: assert property (@(posedge CLOCK_50) disable iff (Reset)
    (r_ps == S_DONE) |-> (w_popcnt == r_chk_n));
`endif
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_bit_pattern_generator.sv
// Directed bench for bit_pattern_generator: scoreboard of expected words, checked on done.
module tb_bit_pattern_generator;
  import bitgen_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] count_in = '0;
  logic             align = 1'b0;
  logic [WIDTH-1:0] pattern;
  logic             busy, done, err, chk_fail;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] pat;
    logic             err;
    int               n;
  } exp_t;

  exp_t sb[$];

  bit_pattern_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .start    (start),
    .count_in (count_in),
    .align    (align),
    .pattern  (pattern),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .chk_fail (chk_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference word built as a mask, independent of any shifting.
  function automatic exp_t model(input int c, input bit a);
    exp_t e;
    logic [WIDTH-1:0] ones;
    ones  = '1;
    e.n   = (c > WIDTH) ? WIDTH : c;
    e.err = (c > WIDTH);
    e.pat = a ? ~(ones >> e.n) : ~(ones << e.n);
    return e;
  endfunction

  task automatic do_txn(input int c, input bit a, input bit perturb);
    exp_t e;
    int   busy_cnt;
    bit   got_done;
    sb.push_back(model(c, a));
    @(negedge clk);
    count_in = CNT_W'(c);
    align    = a;
    start    = 1'b1;
    busy_cnt = 0;
    got_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1;
        break;
      end
      if (busy) busy_cnt++;
      if (perturb && busy_cnt == 1) begin
        start    = 1'b0;
        count_in = CNT_W'($urandom_range(15, 0));
        align    = ~a;
      end
      if (perturb && busy_cnt == 2) start = 1'b1;
    end
    e = sb.pop_front();
    chk("done_seen", 32'(got_done), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'(e.n + 1));
    chk("pattern", 32'(pattern), 32'(e.pat));
    chk("err", 32'(err), 32'(e.err));
    chk("popcount", 32'($countones(pattern)), 32'(e.n));
    chk("chk_fail", 32'(chk_fail), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("done_hold", 32'({done, busy}), 32'b10);
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_flags", 32'({done, busy, err}), 32'b000);
    @(negedge clk);
    chk("idle_pattern", 32'(pattern), 32'(e.pat));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pattern", 32'(pattern), 32'h00);
    chk("rst_flags", 32'({busy, done, err, chk_fail}), 32'b0000);
    rst = 1'b0;

    // Reset three cycles into a fill
    @(negedge clk);
    count_in = 4'd6;
    align    = 1'b0;
    start    = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_fill_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pattern", 32'(pattern), 32'h00);
    chk("rst_mid_flags", 32'({busy, done}), 32'b00);
    chk("rst_mid_ps", 32'(dut.r_ps), 32'(S_IDLE));
    rst   = 1'b0;
    start = 1'b0;

    do_txn(3, 1'b0, 1'b0);
    do_txn(5, 1'b1, 1'b0);
    do_txn(8, 1'b0, 1'b0);
    do_txn(0, 1'b0, 1'b0);
    do_txn(12, 1'b0, 1'b0);
    do_txn(2, 1'b0, 1'b0);
    do_txn(4, 1'b1, 1'b1);
    do_txn(6, 1'b0, 1'b1);

    for (int c = 0; c < 16; c++) begin
      do_txn(c, 1'b0, 1'b0);
      do_txn(c, 1'b1, 1'b0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
